// File: rtl/axi_ni_request_encoder.sv
// axi_ni_request_encoder: round-robin AW/AR arbiter that encodes the granted request into a registered NoC header
module axi_ni_request_encoder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int LEN_WIDTH   = 4,
  parameter int LOCK_WIDTH  = 2,
  parameter int CACHE_WIDTH = 4,
  parameter int PROT_WIDTH  = 3
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       AWVALID,
  output logic                                       AWREADY,
  input  logic [ADDR_WIDTH-1:0]                      AWADDR,
  input  logic [ID_WIDTH-1:0]                        AWID,
  input  logic [LEN_WIDTH-1:0]                       AWLEN,
  input  logic [2:0]                                 AWSIZE,
  input  logic [1:0]                                 AWBURST,
  input  logic [LOCK_WIDTH-1:0]                      AWLOCK,
  input  logic [CACHE_WIDTH-1:0]                     AWCACHE,
  input  logic [PROT_WIDTH-1:0]                      AWPROT,
  input  logic                                       ARVALID,
  output logic                                       ARREADY,
  input  logic [ADDR_WIDTH-1:0]                      ARADDR,
  input  logic [ID_WIDTH-1:0]                        ARID,
  input  logic [LEN_WIDTH-1:0]                       ARLEN,
  input  logic [2:0]                                 ARSIZE,
  input  logic [1:0]                                 ARBURST,
  input  logic [LOCK_WIDTH-1:0]                      ARLOCK,
  input  logic [CACHE_WIDTH-1:0]                     ARCACHE,
  input  logic [PROT_WIDTH-1:0]                      ARPROT,
  output logic                                       hdr_valid,
  input  logic                                       hdr_ready,
  output logic                                       hdr_write,
  output logic [ADDR_WIDTH-1:0]                      hdr_addr,
  output logic [ID_WIDTH-1:0]                        hdr_id,
  output logic [LEN_WIDTH:0]                         hdr_burst_length,
  output logic [1:0]                                 hdr_burst_sequence,
  output logic [2:0]                                 hdr_burst_increment,
  output logic                                       hdr_burst_precise,
  output logic [LOCK_WIDTH+CACHE_WIDTH+PROT_WIDTH-1:0] hdr_attributes,
  output logic                                       hdr_burst_error
);
  localparam int ATTR_WIDTH = LOCK_WIDTH + CACHE_WIDTH + PROT_WIDTH;
  logic last_write, free, grant_write, accept;
  logic [LEN_WIDTH-1:0] len;
  logic [1:0] burst;
  logic [ATTR_WIDTH-1:0] attr;
  always_comb begin
    free = !hdr_valid || hdr_ready;
    grant_write = AWVALID && (!ARVALID || !last_write);
    accept = !reset && free && (AWVALID || ARVALID);
    AWREADY = accept && grant_write;
    ARREADY = accept && !grant_write;
    len = grant_write ? AWLEN : ARLEN;
    burst = grant_write ? AWBURST : ARBURST;
    attr = grant_write ? {AWLOCK, AWCACHE, AWPROT} : {ARLOCK, ARCACHE, ARPROT};
  end
  // A drain and a new accept in the same cycle keep hdr_valid high for back-to-back headers
  always_ff @(posedge clock) begin
    if (reset) begin
      last_write <= 1'b0;
      hdr_valid <= 1'b0;
      hdr_write <= 1'b0;
      hdr_addr <= '0;
      hdr_id <= '0;
      hdr_burst_length <= '0;
      hdr_burst_sequence <= '0;
      hdr_burst_increment <= '0;
      hdr_burst_precise <= 1'b0;
      hdr_attributes <= '0;
      hdr_burst_error <= 1'b0;
    end else if (accept) begin
      last_write <= grant_write;
      hdr_valid <= 1'b1;
      hdr_write <= grant_write;
      hdr_addr <= grant_write ? AWADDR : ARADDR;
      hdr_id <= grant_write ? AWID : ARID;
      hdr_burst_length <= {1'b0, len} + (LEN_WIDTH+1)'(1);
      hdr_burst_sequence <= (burst == 2'd3) ? 2'd0 : burst;
      hdr_burst_increment <= grant_write ? AWSIZE : ARSIZE;
      hdr_burst_precise <= 1'b1;
      hdr_attributes <= attr;
      hdr_burst_error <= burst == 2'd3;
    end else if (hdr_ready) begin
      hdr_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_ni_request_encoder.sv
// tb_axi_ni_request_encoder: scoreboard bench for the AXI-to-NoC request header encoder
module tb_axi_ni_request_encoder;
  typedef struct packed {
    logic       w;
    logic [31:0] addr;
    logic [3:0] id;
    logic [4:0] len;
    logic [1:0] seq;
    logic [2:0] inc;
    logic       prec;
    logic [8:0] attr;
    logic       err;
  } hdr_t;

  logic clock, reset;
  logic AWVALID, AWREADY, ARVALID, ARREADY;
  logic [31:0] AWADDR, ARADDR;
  logic [3:0] AWID, ARID, AWLEN, ARLEN, AWCACHE, ARCACHE;
  logic [2:0] AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0] AWBURST, ARBURST, AWLOCK, ARLOCK;
  logic hdr_valid, hdr_ready, hdr_write, hdr_burst_precise, hdr_burst_error;
  logic [31:0] hdr_addr;
  logic [3:0] hdr_id;
  logic [4:0] hdr_burst_length;
  logic [1:0] hdr_burst_sequence;
  logic [2:0] hdr_burst_increment;
  logic [8:0] hdr_attributes;
  hdr_t obs;
  hdr_t exp_q[$];
  int vecs = 0;
  int errs = 0;

  axi_ni_request_encoder dut (
    .clock(clock), .reset(reset),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_write(hdr_write), .hdr_addr(hdr_addr),
    .hdr_id(hdr_id), .hdr_burst_length(hdr_burst_length), .hdr_burst_sequence(hdr_burst_sequence),
    .hdr_burst_increment(hdr_burst_increment), .hdr_burst_precise(hdr_burst_precise),
    .hdr_attributes(hdr_attributes), .hdr_burst_error(hdr_burst_error)
  );

  assign obs = {hdr_write, hdr_addr, hdr_id, hdr_burst_length, hdr_burst_sequence,
                hdr_burst_increment, hdr_burst_precise, hdr_attributes, hdr_burst_error};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic hdr_t enc(input logic w, input logic [31:0] a, input logic [3:0] id,
                               input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                               input logic [1:0] lock, input logic [3:0] cache, input logic [2:0] prot);
    hdr_t h;
    h.w = w;
    h.addr = a;
    h.id = id;
    h.len = {1'b0, len} + 5'd1;
    case (burst)
      2'd0: h.seq = 2'd0;
      2'd1: h.seq = 2'd1;
      2'd2: h.seq = 2'd2;
      default: h.seq = 2'd0;
    endcase
    h.inc = size;
    h.prec = 1'b1;
    h.attr = {lock, cache, prot};
    h.err = (burst == 2'd3);
    return h;
  endfunction

  task automatic push_exp(input logic w);
    exp_q.push_back(w ? enc(1'b1, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT)
                      : enc(1'b0, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT));
  endtask

  task automatic drive_aw(input logic [31:0] a, input logic [3:0] id, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] lock,
                          input logic [3:0] cache, input logic [2:0] prot);
    AWADDR = a; AWID = id; AWLEN = len; AWSIZE = size;
    AWBURST = burst; AWLOCK = lock; AWCACHE = cache; AWPROT = prot;
  endtask

  task automatic drive_ar(input logic [31:0] a, input logic [3:0] id, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] lock,
                          input logic [3:0] cache, input logic [2:0] prot);
    ARADDR = a; ARID = id; ARLEN = len; ARSIZE = size;
    ARBURST = burst; ARLOCK = lock; ARCACHE = cache; ARPROT = prot;
  endtask

  task automatic test_reset;
    AWVALID = 1'b1;
    ARVALID = 1'b1;
    repeat (2) @(negedge clock);
    vecs++;
    if (AWREADY !== 1'b0 || ARREADY !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready: awready=%b arready=%b want 0 0", AWREADY, ARREADY);
    end
    vecs++;
    if ({hdr_valid, obs} !== '0) begin
      errs++;
      $display("FAIL reset_state: valid=%b hdr=%h want all zero", hdr_valid, obs);
    end
    AWVALID = 1'b0;
    ARVALID = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_contention;
    hdr_t e;
    logic want_w;
    hdr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i > 0) begin
        e = exp_q.pop_front();
        vecs++;
        if (hdr_valid !== 1'b1 || obs !== e) begin
          errs++;
          $display("FAIL contention_hdr%0d: valid=%b got %h want %h", i - 1, hdr_valid, obs, e);
        end
      end
      AWVALID = 1'b1;
      ARVALID = 1'b1;
      drive_aw(32'h1000 + i, 4'(i), 4'(i), 3'd2, 2'd1, 2'b00, 4'b0001, 3'b001);
      drive_ar(32'h2000 + i, 4'(i + 8), 4'(i + 1), 3'd1, 2'd0, 2'b01, 4'b0010, 3'b100);
      want_w = (i % 2 == 0);
      #1;
      vecs++;
      if (AWREADY !== want_w || ARREADY !== !want_w) begin
        errs++;
        $display("FAIL contention_grant%0d: awready=%b arready=%b want %b %b", i, AWREADY, ARREADY, want_w, !want_w);
      end
      push_exp(want_w);
    end
    @(negedge clock);
    AWVALID = 1'b0;
    ARVALID = 1'b0;
    e = exp_q.pop_front();
    vecs++;
    if (hdr_valid !== 1'b1 || obs !== e) begin
      errs++;
      $display("FAIL contention_hdr3: valid=%b got %h want %h", hdr_valid, obs, e);
    end
    @(negedge clock);
    vecs++;
    if (hdr_valid !== 1'b0) begin
      errs++;
      $display("FAIL contention_drain: valid=%b want 0", hdr_valid);
    end
  endtask

  task automatic test_single_write;
    hdr_t e;
    @(negedge clock);
    drive_aw(32'hA000_0040, 4'h5, 4'd3, 3'd2, 2'd1, 2'b00, 4'b0011, 3'b010);
    AWVALID = 1'b1;
    hdr_ready = 1'b1;
    #1;
    vecs++;
    if (AWREADY !== 1'b1 || ARREADY !== 1'b0) begin
      errs++;
      $display("FAIL single_ready: awready=%b arready=%b want 1 0", AWREADY, ARREADY);
    end
    push_exp(1'b1);
    @(negedge clock);
    AWVALID = 1'b0;
    e = exp_q.pop_front();
    vecs++;
    if (hdr_valid !== 1'b1 || obs !== e || hdr_burst_length !== 5'd4 || hdr_attributes !== 9'b00_0011_010) begin
      errs++;
      $display("FAIL single_hdr: valid=%b got %h want %h", hdr_valid, obs, e);
    end
    @(negedge clock);
    vecs++;
    if (hdr_valid !== 1'b0 || obs !== e) begin
      errs++;
      $display("FAIL drain_hold: valid=%b got %h want 0 and %h", hdr_valid, obs, e);
    end
  endtask

  task automatic test_backpressure;
    hdr_t e;
    @(negedge clock);
    drive_ar(32'hB000_0000, 4'h3, 4'd7, 3'd3, 2'd2, 2'b01, 4'b1111, 3'b000);
    ARVALID = 1'b1;
    hdr_ready = 1'b0;
    #1;
    vecs++;
    if (ARREADY !== 1'b1 || AWREADY !== 1'b0) begin
      errs++;
      $display("FAIL stall_accept: arready=%b awready=%b want 1 0", ARREADY, AWREADY);
    end
    push_exp(1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k == 0) begin
        ARVALID = 1'b0;
        drive_aw(32'hC000_0100, 4'h9, 4'd0, 3'd0, 2'd0, 2'b10, 4'b0100, 3'b011);
        AWVALID = 1'b1;
      end
      #1;
      vecs++;
      if (hdr_valid !== 1'b1 || obs !== exp_q[0] || AWREADY !== 1'b0 || ARREADY !== 1'b0) begin
        errs++;
        $display("FAIL stall_hold%0d: valid=%b got %h want %h awready=%b arready=%b", k, hdr_valid, obs, exp_q[0], AWREADY, ARREADY);
      end
    end
    @(negedge clock);
    hdr_ready = 1'b1;
    #1;
    vecs++;
    if (AWREADY !== 1'b1 || ARREADY !== 1'b0) begin
      errs++;
      $display("FAIL stall_release: awready=%b arready=%b want 1 0", AWREADY, ARREADY);
    end
    e = exp_q.pop_front();
    vecs++;
    if (hdr_valid !== 1'b1 || obs !== e) begin
      errs++;
      $display("FAIL stall_read_hdr: valid=%b got %h want %h", hdr_valid, obs, e);
    end
    push_exp(1'b1);
    @(negedge clock);
    AWVALID = 1'b0;
    e = exp_q.pop_front();
    vecs++;
    if (hdr_valid !== 1'b1 || obs !== e) begin
      errs++;
      $display("FAIL stall_write_hdr: valid=%b got %h want %h", hdr_valid, obs, e);
    end
    @(negedge clock);
  endtask

  task automatic test_boundaries;
    hdr_t e;
    logic w, ok;
    hdr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      w = (k != 0);
      case (k)
        0: drive_ar(32'h0000_0FF0, 4'hF, 4'd15, 3'd0, 2'd1, 2'b10, 4'b0110, 3'b111);
        1: drive_aw(32'h0000_1000, 4'h1, 4'd3, 3'd2, 2'd2, 2'b01, 4'b1010, 3'b101);
        2: drive_aw(32'h0000_2000, 4'h2, 4'd1, 3'd1, 2'd3, 2'b11, 4'b0000, 3'b000);
        default: drive_aw(32'h0000_3000, 4'h3, 4'd0, 3'd7, 2'd1, 2'b00, 4'b1111, 3'b110);
      endcase
      AWVALID = w;
      ARVALID = !w;
      #1;
      vecs++;
      if (AWREADY !== w || ARREADY !== !w) begin
        errs++;
        $display("FAIL bound_ready%0d: awready=%b arready=%b want %b %b", k, AWREADY, ARREADY, w, !w);
      end
      push_exp(w);
      @(negedge clock);
      AWVALID = 1'b0;
      ARVALID = 1'b0;
      e = exp_q.pop_front();
      case (k)
        0: ok = hdr_burst_length === 5'd16;
        1: ok = hdr_burst_sequence === 2'd2;
        2: ok = hdr_burst_sequence === 2'd0 && hdr_burst_error === 1'b1;
        default: ok = hdr_burst_increment === 3'd7;
      endcase
      vecs++;
      if (hdr_valid !== 1'b1 || obs !== e || !ok) begin
        errs++;
        $display("FAIL bound_hdr%0d: valid=%b got %h want %h", k, hdr_valid, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_stall;
    hdr_t e;
    @(negedge clock);
    hdr_ready = 1'b0;
    drive_aw(32'hDEAD_BEE0, 4'h1, 4'd1, 3'd1, 2'd1, 2'b00, 4'b0000, 3'b000);
    AWVALID = 1'b1;
    @(negedge clock);
    AWVALID = 1'b0;
    vecs++;
    if (hdr_valid !== 1'b1) begin
      errs++;
      $display("FAIL midreset_pending: valid=%b want 1", hdr_valid);
    end
    reset = 1'b1;
    drive_ar(32'h5555_0000, 4'h6, 4'd2, 3'd2, 2'd1, 2'b00, 4'b0001, 3'b000);
    AWVALID = 1'b1;
    ARVALID = 1'b1;
    #1;
    vecs++;
    if (AWREADY !== 1'b0 || ARREADY !== 1'b0) begin
      errs++;
      $display("FAIL midreset_ready: awready=%b arready=%b want 0 0", AWREADY, ARREADY);
    end
    @(negedge clock);
    reset = 1'b0;
    vecs++;
    if ({hdr_valid, obs} !== '0) begin
      errs++;
      $display("FAIL midreset_clear: valid=%b hdr=%h want all zero", hdr_valid, obs);
    end
    #1;
    vecs++;
    if (AWREADY !== 1'b1 || ARREADY !== 1'b0) begin
      errs++;
      $display("FAIL midreset_grant: awready=%b arready=%b want 1 0", AWREADY, ARREADY);
    end
    push_exp(1'b1);
    hdr_ready = 1'b1;
    @(negedge clock);
    AWVALID = 1'b0;
    ARVALID = 1'b0;
    e = exp_q.pop_front();
    vecs++;
    if (hdr_valid !== 1'b1 || obs !== e) begin
      errs++;
      $display("FAIL midreset_hdr: valid=%b got %h want %h", hdr_valid, obs, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    hdr_ready = 1'b0;
    AWVALID = 1'b0;
    ARVALID = 1'b0;
    drive_aw('0, '0, '0, '0, '0, '0, '0, '0);
    drive_ar('0, '0, '0, '0, '0, '0, '0, '0);
    test_reset;
    test_contention;
    test_single_write;
    test_backpressure;
    test_boundaries;
    test_reset_mid_stall;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/axi_ni_request_encoder.md
Name: axi_ni_request_encoder

Overview:
- Initiator-side NI block that turns AXI AW/AR address-channel requests into NoC request-header fields for the packetizer.
- Arbitrates AW against AR round-robin and encodes LEN/SIZE/BURST/LOCK/CACHE/PROT into packet burst and attribute fields.
- Holds the encoded header in a single registered output stage with a valid/ready handshake toward the packet builder.
- Its encodings are the exact inverse of the target-side receive decoding.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 4, AXI ID width.
- LEN_WIDTH, 4, AXI LEN width; burst length field is LEN_WIDTH+1 bits.
- LOCK_WIDTH, 2, AXI LOCK width.
- CACHE_WIDTH, 4, AXI CACHE width.
- PROT_WIDTH, 3, AXI PROT width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- AWVALID/AWREADY  in/out  1/1  write address handshake.
- AWADDR, AWID, AWLEN, AWSIZE(3), AWBURST(2), AWLOCK, AWCACHE, AWPROT  in  param widths  write address payload.
- ARVALID/ARREADY  in/out  1/1  read address handshake.
- ARADDR, ARID, ARLEN, ARSIZE(3), ARBURST(2), ARLOCK, ARCACHE, ARPROT  in  param widths  read address payload.
- hdr_valid  out  1  encoded header available.
- hdr_ready  in  1  packet builder accepts header.
- hdr_write  out  1  1 = write request, 0 = read request.
- hdr_addr  out  ADDR_WIDTH  request address.
- hdr_id  out  ID_WIDTH  transaction ID.
- hdr_burst_length  out  LEN_WIDTH+1  number of beats.
- hdr_burst_sequence  out  2  STRM=0, INCR=1, WRAP=2.
- hdr_burst_increment  out  3  bytes-per-beat log2.
- hdr_burst_precise  out  1  precise-burst flag.
- hdr_attributes  out  LOCK+CACHE+PROT  packed attributes.
- hdr_burst_error  out  1  reserved AXI burst type (3) was encoded.

Behaviour:
- Reset: hdr_valid=0; all hdr_* data outputs=0; AWREADY=ARREADY=0 during reset; last_grant=READ, so the first contention grants WRITE.
- Output stage is free when hdr_valid=0, or when hdr_valid=1 and hdr_ready=1 in the same cycle (pass-through drain).
- accept = stage free AND (AWVALID or ARVALID).
- Arbitration:
  - Only one of AWVALID/ARVALID high: that channel is granted.
  - Both high: grant the channel opposite to last_grant.
  - last_grant updates only on an accepted grant.
- AWREADY = stage free AND grant==WRITE AND AWVALID; ARREADY likewise. Both are combinational from registered state plus inputs and are never high together.
- On a handshake, the output registers load next edge (latency 1 cycle, VALID-to-hdr_valid):
  - hdr_burst_length = LEN+1 zero-extended (LEN=all ones gives 2^LEN_WIDTH, no wrap).
  - hdr_burst_increment = SIZE (identity).
  - hdr_burst_sequence: FIXED→STRM, INCR→INCR, WRAP→WRAP, 3→STRM with hdr_burst_error=1.
  - hdr_burst_precise = 1.
  - hdr_attributes = {LOCK, CACHE, PROT}, with PROT in the LSBs.
  - hdr_write = granted channel.
- hdr_valid=1 with hdr_ready=0: all hdr_* outputs hold stable; AWREADY=ARREADY=0.
- Simultaneous drain and accept: new header replaces old at the edge; hdr_valid stays 1 (back-to-back, 1 header/cycle).
- Drain without accept: hdr_valid←0, data outputs hold last value.
- Reset mid-operation: pending header is discarded, hdr_valid←0, arbiter back to reset state; AXI requests not yet handshaken stay pending at the source.
- The block does not inspect address, ID, or 4KB crossing; fields pass through unmodified.

Test Plan:
- Single write: AWLEN=3, AWSIZE=2, AWBURST=1, AWLOCK=0, AWCACHE=4'b0011, AWPROT=3'b010, hdr_ready=1 -> AWREADY same cycle; next cycle hdr_valid=1, hdr_write=1, burst_length=4, increment=2, sequence=1, precise=1, attributes=9'b00_0011_010.
- Contention: AWVALID and ARVALID held high for 4 cycles, hdr_ready=1 -> grant order W,R,W,R; one header per cycle; ARREADY and AWREADY never both high.
- Backpressure: read header with hdr_ready=0 for 5 cycles -> hdr_* stable; ARREADY=AWREADY=0 throughout; on hdr_ready=1, next request accepted in that same cycle.
- Boundaries: ARLEN=15 -> burst_length=16; AWBURST=2 -> sequence=2; AWBURST=3 -> sequence=0 with burst_error=1; AWSIZE=7 -> increment=7.
- Reset mid-stall: hdr_valid=1, hdr_ready=0, assert reset for 1 cycle -> hdr_valid=0 and outputs 0 next edge; with both channels valid after reset, WRITE is granted first.
